clause_checker_seq: RTL and testbench
=====================================

Name: clause_checker_seq

Overview:
- Sequential, parametrised clause-satisfiability checker.
- Evaluates NUM_CLAUSES linear integer clauses of the form sum(a_j*y_j) + a_const <= 0 (or a selectable relation) over NUM_VARS signed variables.
- Uses one multiply-accumulate per clause per cycle, iterating over the variables, with an accumulator widened so results never wrap.
- Sits between the assignment proposer and the MCMC acceptance logic; a start/valid handshake replaces the earlier purely combinational check.

Parameters:
- NUM_VARS, 2, number of integer variables y_j.
- NUM_CLAUSES, 2, number of clauses evaluated in parallel.
- BIT_WIDTH, 8, signed width of every coefficient and variable.
- ACC_WIDTH, 2*BIT_WIDTH+$clog2(NUM_VARS+1), signed accumulator width (18 at defaults).

Ports:
- in_clk  input  1  clock, rising edge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_enable  input  1  advance enable; when low, the FSM and datapath hold.
- in_start  input  1  start request, sampled only in IDLE with in_enable=1.
- in_relation_mode  input  2  00: result<=0; 01: result<0; 10: result==0; 11: treated as 00.
- in_coefficients  input  NUM_CLAUSES*(NUM_VARS+1)*BIT_WIDTH  clause c, term j at [((c*(NUM_VARS+1)+j)*BIT_WIDTH) +: BIT_WIDTH]; j=NUM_VARS is the constant term.
- in_current_assignment  input  NUM_VARS*BIT_WIDTH  y_j at [j*BIT_WIDTH +: BIT_WIDTH].
- out_busy  output  1  high in ACCUM and COMPARE.
- out_valid  output  1  one-cycle pulse; results valid.
- out_clause_flags  output  NUM_CLAUSES  bit c =1 means clause c is satisfied.
- out_all_sat  output  1  AND of all flags.
- out_unsat_count  output  $clog2(NUM_CLAUSES+1)  number of unsatisfied clauses.

Behaviour:
- Reset (asynchronous assert, any state): go to IDLE. out_busy=0, out_valid=0, out_clause_flags=0, out_all_sat=0, out_unsat_count=0. Accumulators, index and latched operands are all cleared.
- Reset asserted mid-operation aborts the evaluation; no out_valid is produced.
- IDLE, with in_start=1 and in_enable=1 at an edge:
  - Latch in_coefficients, in_current_assignment and in_relation_mode.
  - Load acc[c] = sign-extended constant term of clause c.
  - Set idx=0 and go to ACCUM.
  - Later input changes do not affect the running evaluation.
- ACCUM, each edge with in_enable=1:
  - acc[c] += a[c][idx]*y[idx], a full signed BIT_WIDTH x BIT_WIDTH product sign-extended to ACC_WIDTH.
  - Increment idx. After the idx=NUM_VARS-1 term, go to COMPARE.
- COMPARE, edge with in_enable=1:
  - Register flag[c] from acc[c] according to the latched mode.
  - Register out_all_sat and out_unsat_count from those flags.
  - Set out_valid=1 and go to IDLE.
- out_valid is high for exactly the one cycle after the COMPARE edge, then cleared.
- Result outputs hold their values until the next COMPARE edge or a reset.
- Latency with in_enable held high: start sampled at edge k, out_valid high during the cycle after edge k+NUM_VARS+1. Each enable-low cycle adds one cycle.
- in_enable=0: the state, idx, accumulators and out_valid (pulse extended) all hold.
- in_start while busy: ignored, not queued. in_start in the same cycle out_valid is high (state IDLE): accepted; back-to-back evaluations are legal.
- Arithmetic:
  - All signed two's complement.
  - Only the ACC_WIDTH default is guaranteed overflow-free; smaller overrides are unsupported.
  - Most-negative operands (-2^(BIT_WIDTH-1)) must be handled exactly.
- NUM_VARS=1 is legal: one ACCUM cycle.

Test Plan:
- Defaults, mode 00.
  - Clause0 = (1,1,-5), clause1 = (2,-1,0), y=(2,3), start.
  - Expected: out_valid 3 cycles after start edge; flags=2'b01 (clause0 result 0, clause1 result 1); all_sat=0; unsat_count=1.
- Overflow.
  - Clause0 = (127,127,127), clause1 = (-128,-128,-128), y=(127,127).
  - Expected: results +32385 and -32640 (no wrap); flags=2'b10; unsat_count=1.
- Modes, same operands as the first scenario.
  - Mode 01: flags=2'b00, unsat_count=2.
  - Mode 10: flags=2'b01.
  - Mode 11: same as mode 00.
- Stall and ignore.
  - Drop in_enable for 2 cycles during ACCUM: out_valid arrives at 5 cycles, same flags.
  - in_start pulsed while busy and operands changed mid-run: result unchanged; exactly one out_valid.
- Reset mid-operation.
  - Assert in_reset_n=0 during ACCUM: all outputs 0 immediately; no out_valid after release.
  - A new start after release evaluates correctly.
- Back-to-back.
  - in_start held high across out_valid with new y=(0,0).
  - Expected: second out_valid 3 cycles later; flags=2'b11; all_sat=1; unsat_count=0.

Source files
------------

// File: rtl/clause_checker_seq.sv
// Sequential clause checker: one signed MAC per clause per cycle over the variables,
// then a relational compare of each widened accumulator against zero.
//   state     | meaning
//   S_IDLE    | waiting for start, results held
//   S_ACCUM   | one product term per clause per enabled edge
//   S_COMPARE | register flags, summary and the valid pulse
module clause_checker_seq #(
  parameter int NUM_VARS    = 2,
  parameter int NUM_CLAUSES = 2,
  parameter int BIT_WIDTH   = 8,
  parameter int ACC_WIDTH   = 2*BIT_WIDTH+$clog2(NUM_VARS+1)
) (
  input  logic                                        in_clk,
  input  logic                                        in_reset_n,
  input  logic                                        in_enable,
  input  logic                                        in_start,
  input  logic [1:0]                                  in_relation_mode,
  input  logic [NUM_CLAUSES*(NUM_VARS+1)*BIT_WIDTH-1:0] in_coefficients,
  input  logic [NUM_VARS*BIT_WIDTH-1:0]               in_current_assignment,
  output logic                                        out_busy,
  output logic                                        out_valid,
  output logic [NUM_CLAUSES-1:0]                      out_clause_flags,
  output logic                                        out_all_sat,
  output logic [$clog2(NUM_CLAUSES+1)-1:0]            out_unsat_count
);

  localparam int IDX_W  = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int CNT_W  = $clog2(NUM_CLAUSES+1);
  localparam int PROD_W = 2*BIT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COMPARE} state_e;

  state_e                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [1:0]                    mode_q;
  logic signed [BIT_WIDTH-1:0]   coef_q [NUM_CLAUSES][NUM_VARS];
  logic signed [BIT_WIDTH-1:0]   y_q    [NUM_VARS];
  logic signed [ACC_WIDTH-1:0]   acc_q  [NUM_CLAUSES];
  logic                          valid_q;
  logic                          all_sat_q;
  logic [NUM_CLAUSES-1:0]        flags_q;
  logic [CNT_W-1:0]              unsat_q;

  logic signed [BIT_WIDTH-1:0]   coef_in   [NUM_CLAUSES][NUM_VARS+1];
  logic signed [BIT_WIDTH-1:0]   y_in      [NUM_VARS];
  logic signed [ACC_WIDTH-1:0]   const_ext [NUM_CLAUSES];
  logic signed [BIT_WIDTH-1:0]   a_sel     [NUM_CLAUSES];
  logic signed [BIT_WIDTH-1:0]   y_sel;
  logic signed [PROD_W-1:0]      prod      [NUM_CLAUSES];
  logic signed [ACC_WIDTH-1:0]   acc_d     [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0]        flags_d;
  logic [CNT_W-1:0]              unsat_d;

  always_comb begin
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      for (int j = 0; j <= NUM_VARS; j++) begin
        coef_in[c][j] = in_coefficients[(c*(NUM_VARS+1)+j)*BIT_WIDTH +: BIT_WIDTH];
      end
    end
    for (int j = 0; j < NUM_VARS; j++) begin
      y_in[j] = in_current_assignment[j*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Operand muxes select term idx; products are sign-extended in full before accumulation.
  always_comb begin
    y_sel = '0;
    for (int j = 0; j < NUM_VARS; j++) begin
      if (idx_q == IDX_W'(j)) y_sel = y_q[j];
    end
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      a_sel[c] = '0;
      for (int j = 0; j < NUM_VARS; j++) begin
        if (idx_q == IDX_W'(j)) a_sel[c] = coef_q[c][j];
      end
      prod[c] = $signed({{BIT_WIDTH{a_sel[c][BIT_WIDTH-1]}}, a_sel[c]}) *
                $signed({{BIT_WIDTH{y_sel[BIT_WIDTH-1]}}, y_sel});
      acc_d[c] = acc_q[c] + {{(ACC_WIDTH-PROD_W){prod[c][PROD_W-1]}}, prod[c]};
      const_ext[c] = {{(ACC_WIDTH-BIT_WIDTH){coef_in[c][NUM_VARS][BIT_WIDTH-1]}},
                      coef_in[c][NUM_VARS]};
    end
  end

  always_comb begin
    flags_d = '0;
    unsat_d = '0;
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      case (mode_q)
        2'b01:   flags_d[c] = acc_q[c][ACC_WIDTH-1];
        2'b10:   flags_d[c] = (acc_q[c] == '0);
        default: flags_d[c] = acc_q[c][ACC_WIDTH-1] | (acc_q[c] == '0);
      endcase
      if (!flags_d[c]) unsat_d = unsat_d + CNT_W'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mode_q    <= '0;
      valid_q   <= 1'b0;
      all_sat_q <= 1'b0;
      flags_q   <= '0;
      unsat_q   <= '0;
      for (int c = 0; c < NUM_CLAUSES; c++) begin
        acc_q[c] <= '0;
        for (int j = 0; j < NUM_VARS; j++) coef_q[c][j] <= '0;
      end
      for (int j = 0; j < NUM_VARS; j++) y_q[j] <= '0;
    end else if (in_enable) begin
      valid_q <= (state_q == S_COMPARE);
      case (state_q)
        S_IDLE: begin
          if (in_start) begin
            mode_q <= in_relation_mode;
            idx_q  <= '0;
            for (int c = 0; c < NUM_CLAUSES; c++) begin
              acc_q[c] <= const_ext[c];
              for (int j = 0; j < NUM_VARS; j++) coef_q[c][j] <= coef_in[c][j];
            end
            for (int j = 0; j < NUM_VARS; j++) y_q[j] <= y_in[j];
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int c = 0; c < NUM_CLAUSES; c++) acc_q[c] <= acc_d[c];
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_VARS-1)) state_q <= S_COMPARE;
        end
        S_COMPARE: begin
          flags_q   <= flags_d;
          all_sat_q <= &flags_d;
          unsat_q   <= unsat_d;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_busy         = (state_q != S_IDLE);
  assign out_valid        = valid_q;
  assign out_clause_flags = flags_q;
  assign out_all_sat      = all_sat_q;
  assign out_unsat_count  = unsat_q;

endmodule

// File: tb/tb_clause_checker_seq.sv
// Bench for clause_checker_seq: directed scenarios plus randomized clauses checked
// against an integer-arithmetic reference model.
module tb_clause_checker_seq;
  localparam int NV   = 2;
  localparam int NC   = 2;
  localparam int BW   = 8;
  localparam int CW   = NC*(NV+1)*BW;
  localparam int YW   = NV*BW;
  localparam int CNTW = $clog2(NC+1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic [CW-1:0]   coefs = '0;
  logic [YW-1:0]   yv = '0;
  logic            busy, valid, all_sat;
  logic [NC-1:0]   flags;
  logic [CNTW-1:0] unsat;

  int vectors = 0;
  int miscompares = 0;

  clause_checker_seq dut (
    .in_clk(clk), .in_reset_n(rst_n), .in_enable(en), .in_start(start),
    .in_relation_mode(mode), .in_coefficients(coefs), .in_current_assignment(yv),
    .out_busy(busy), .out_valid(valid), .out_clause_flags(flags),
    .out_all_sat(all_sat), .out_unsat_count(unsat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack(input int a0, input int b0, input int k0,
                                         input int a1, input int b1, input int k1);
    return {BW'(k1), BW'(b1), BW'(a1), BW'(k0), BW'(b0), BW'(a0)};
  endfunction

  function automatic logic [YW-1:0] ypack(input int y0, input int y1);
    return {BW'(y1), BW'(y0)};
  endfunction

  function automatic logic [NC-1:0] model_flags(input logic [CW-1:0] cv,
                                                input logic [YW-1:0] yvec,
                                                input logic [1:0] md);
    logic [NC-1:0] f;
    logic [BW-1:0] s, t;
    int r;
    f = '0;
    for (int c = 0; c < NC; c++) begin
      s = cv[(c*(NV+1)+NV)*BW +: BW];
      r = int'($signed(s));
      for (int j = 0; j < NV; j++) begin
        s = cv[(c*(NV+1)+j)*BW +: BW];
        t = yvec[j*BW +: BW];
        r = r + int'($signed(s)) * int'($signed(t));
      end
      case (md)
        2'b01:   f[c] = (r < 0);
        2'b10:   f[c] = (r == 0);
        default: f[c] = (r <= 0);
      endcase
    end
    return f;
  endfunction

  // Entered just after a rising edge; returns just after the edge that ends the valid pulse.
  task automatic do_eval(input string tag, input logic [CW-1:0] cv, input logic [YW-1:0] yvec,
                         input logic [1:0] md, input int stall);
    logic [NC-1:0] ef;
    int lat;
    bit seen;
    ef = model_flags(cv, yvec, md);
    coefs = cv; yv = yvec; mode = md; en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    en = (stall == 0);
    chk({tag, "_busy"}, busy, 1);
    lat = 0; seen = 0;
    while (!seen && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (lat == stall) en = 1'b1;
      if (valid) seen = 1;
    end
    chk({tag, "_latency"}, lat, 3 + stall);
    chk({tag, "_flags"}, flags, ef);
    chk({tag, "_all_sat"}, all_sat, &ef);
    chk({tag, "_unsat"}, unsat, NC - $countones(ef));
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, valid, 0);
  endtask

  initial begin
    logic [CW-1:0] base_c;
    logic [YW-1:0] base_y;
    logic [CW-1:0] rc;
    logic [YW-1:0] ry;
    logic [NC-1:0] got;
    int nval, lat, r, v;

    base_c = pack(1, 1, -5, 2, -1, 0);
    base_y = ypack(2, 3);

    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_all_sat", all_sat, 0);
    chk("rst_unsat", unsat, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_eval("base", base_c, base_y, 2'b00, 0);
    chk("base_plan_flags", flags, 2'b01);
    do_eval("ovf", pack(127, 127, 127, -128, -128, -128), ypack(127, 127), 2'b00, 0);
    chk("ovf_plan_flags", flags, 2'b10);
    do_eval("mode01", base_c, base_y, 2'b01, 0);
    chk("mode01_plan_unsat", unsat, 2);
    do_eval("mode10", base_c, base_y, 2'b10, 0);
    chk("mode10_plan_flags", flags, 2'b01);
    do_eval("mode11", base_c, base_y, 2'b11, 0);
    chk("mode11_plan_flags", flags, 2'b01);
    do_eval("stall", base_c, base_y, 2'b00, 2);
    do_eval("onevar_edge", pack(-128, 0, -128, -128, -128, 0), ypack(-128, 0), 2'b00, 0);

    // Operands and start change while busy: the first evaluation must stand alone.
    coefs = base_c; yv = base_y; mode = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    coefs = pack(-1, -1, 50, 3, 3, 3); yv = ypack(-7, 9); mode = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    nval = 0; got = '0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid) begin nval++; got = flags; end
    end
    chk("midrun_valid_count", nval, 1);
    chk("midrun_flags", got, 2'b01);

    // Reset during ACCUM clears everything immediately and suppresses the result.
    coefs = base_c; yv = base_y; mode = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_all_sat", all_sat, 0);
    chk("midrst_unsat", unsat, 0);
    #2 rst_n = 1'b1;
    nval = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (valid) nval++;
    end
    chk("midrst_no_valid", nval, 0);
    do_eval("after_rst", base_c, base_y, 2'b00, 0);

    // Start held across the valid cycle: second evaluation accepted while valid is high.
    coefs = base_c; yv = base_y; mode = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!valid && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("b2b_first_latency", lat, 3);
    chk("b2b_first_flags", flags, 2'b01);
    yv = ypack(0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_valid_drop", valid, 0);
    lat = 0;
    while (!valid && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("b2b_second_latency", lat, 3);
    chk("b2b_flags", flags, 2'b11);
    chk("b2b_all_sat", all_sat, 1);
    chk("b2b_unsat", unsat, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) begin
      for (int t = 0; t < NC*(NV+1); t++) begin
        r = int'($urandom_range(0, 7));
        if (r == 0) v = -128;
        else if (r == 1) v = 127;
        else if (r < 5) v = int'($urandom_range(0, 6)) - 3;
        else v = int'($urandom_range(0, 255)) - 128;
        rc[t*BW +: BW] = BW'(v);
      end
      for (int j = 0; j < NV; j++) begin
        r = int'($urandom_range(0, 5));
        if (r == 0) v = -128;
        else if (r < 3) v = int'($urandom_range(0, 4)) - 2;
        else v = int'($urandom_range(0, 255)) - 128;
        ry[j*BW +: BW] = BW'(v);
      end
      do_eval("rand", rc, ry, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
